synapse_weight_arbiter: RTL and testbench
=========================================

# synapse_weight_arbiter

Shares the single-port synaptic weight RAM between NUM_REQ spike-processing read engines and one configuration port fed by the AXI4-Lite slave. Each cycle it grants at most one access and issues it to the RAM. Out-of-range addresses are rejected without touching memory. Responses are returned on a fixed two-cycle pipeline. It sits between the AXI register/memory front end and the weight RAM macro, so the RAM itself stays a plain single-port array.

## Interface
- NUM_SYNAPSES, 72903: weight entries; legal addresses 0..NUM_SYNAPSES-1
- ADDR_W, 17: address width, must satisfy 2^ADDR_W >= NUM_SYNAPSES
- WEIGHT_W, 16: weight width
- NUM_REQ, 4: number of read requesters (>=1)
- CFG_BURST_MAX, 8: max consecutive config grants while any read request is pending

- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- rd_req_valid  input  NUM_REQ  per-requester read request
- rd_req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- rd_req_ready  output  NUM_REQ  one-hot grant/accept
- rd_rsp_valid  output  NUM_REQ  one-hot response strobe
- rd_rsp_data  output  WEIGHT_W  shared response data
- rd_rsp_err  output  1  address out of range
- cfg_valid  input  1  config request
- cfg_we  input  1  1 = write, 0 = read
- cfg_addr  input  ADDR_W  config address
- cfg_wdata  input  WEIGHT_W  write data
- cfg_ready  output  1  config accept
- cfg_rsp_valid  output  1  config completion strobe (reads and writes)
- cfg_rsp_rdata  output  WEIGHT_W  read data; 0 for writes and errors
- cfg_rsp_err  output  1  address out of range
- mem_en  output  1  RAM access enable
- mem_we  output  1  RAM write enable
- mem_addr  output  ADDR_W  RAM address
- mem_wdata  output  WEIGHT_W  RAM write data
- mem_rdata  input  WEIGHT_W  RAM read data, valid 1 cycle after mem_en

## Operation
- A request is accepted in a cycle when valid && ready. At most one acceptance per cycle across all ports.
- rd_req_ready and cfg_ready are combinational from the valids and registered arbiter state. A requester must hold valid and addr stable until it is accepted.
- Priority: config wins over reads, with one exception. If cfg_streak == CFG_BURST_MAX and any rd_req_valid is high, cfg_ready=0 and a read is granted instead.
- cfg_streak increments on each config grant, saturating at CFG_BURST_MAX. It clears on any cycle without a config grant.
- Read grant is round-robin. The search starts at last_grant+1 mod NUM_REQ. last_grant updates only on a read grant. Reset value of last_grant is NUM_REQ-1, so requester 0 is favoured first.
- Range check on the accepted address: addr >= NUM_SYNAPSES sets err. An erroring request keeps mem_en=0 but still produces a response with data 0 and err=1.
- Config write: mem_we=1, mem_wdata=cfg_wdata. The completion strobe reports err only.
- Two-stage pipeline entry {valid, is_cfg, req_id, err}. Stage 1 drives the mem_* signals; stage 2 qualifies mem_rdata into the response.

## Timing
- Accept in cycle T.
- mem_en/mem_we/mem_addr/mem_wdata are registered and asserted in T+1.
- Response strobe in T+2:
  - rd_rsp_valid[id] or cfg_rsp_valid.
  - Data is taken from mem_rdata (reads) or forced to 0 (writes/errors).
- Throughput: 1 access/cycle, back-to-back, no bubbles.
- Responses are not backpressured; consumers must sink them.
- Read-after-write to the same address is issued in order. A read accepted at T+1 after a write at T returns the new value (the RAM sees the write first).
- Simultaneous cfg_valid and all rd_req_valid: config granted until the streak limit, then exactly one read, then config again.
- Reset values of all outputs: 0, including rd_req_ready and cfg_ready.
- Reset asserted mid-operation: pipeline entries are discarded immediately, no response is ever issued for in-flight requests, cfg_streak=0, last_grant=NUM_REQ-1.

## Structure
- Package synapse_mem_pkg holds:
  - the pipeline entry struct type;
  - the response error encoding;
  - default constants for NUM_SYNAPSES, ADDR_W and WEIGHT_W, shared with the AXI memory front end.
- One sub-module, rr_arbiter: parameter N; inputs req[N] and advance; outputs grant[N] one-hot and grant_idx. It owns the last_grant pointer. The top level adds config priority, the streak counter, the range check and the pipeline.

## Test plan
- Single read: requester 2 reads addr 5 after a config write of 0x1234 to addr 5 -> at T+2, rd_rsp_valid=4'b0100, data 0x1234, err 0.
- Round-robin: all 4 requesters held valid -> grants 0,1,2,3,0,… one per cycle; each response arrives on the matching rd_rsp_valid bit 2 cycles later.
- Starvation guard: cfg_valid held with 20 requests plus rd_req_valid[1] held -> 8 config grants, 1 read grant, 8 config grants, repeating.
- Out of range: cfg read at addr 72903, then requester 0 at 100000 -> mem_en never asserts; both responses have err=1 and data 0.
- Reset mid-stream: rst low one cycle after accepting two reads -> all outputs 0 within the reset cycle, no rd_rsp_valid afterwards; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/synapse_mem_pkg.sv
// Shared types and default geometry for the synaptic weight memory path.
// The AXI memory front end uses the same defaults.
package synapse_mem_pkg;

    localparam int SYN_NUM_SYNAPSES = 72903;
    localparam int SYN_ADDR_W       = 17;
    localparam int SYN_WEIGHT_W     = 16;
    localparam int REQ_ID_W         = 8;

    typedef enum logic {
        RSP_OK        = 1'b0,
        RSP_ERR_RANGE = 1'b1
    } rsp_err_e;

    // is_wr lets the response stage force write completions to zero data
    typedef struct packed {
        logic                valid;
        logic                is_cfg;
        logic                is_wr;
        logic [REQ_ID_W-1:0] req_id;
        rsp_err_e            err;
    } pipe_entry_t;

endpackage

// File: rtl/synapse_weight_arbiter_rr_arbiter.sv
// Round-robin arbiter; search starts one past the last granted requester.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    // Walk from farthest to nearest so the nearest requester overrides
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = int'(last_grant) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                grant           = '0;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= IDX_W'(N - 1);
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/synapse_weight_arbiter.sv
// Arbitrates the single-port weight RAM between NUM_REQ read engines and the
// configuration port, with range checking and a fixed two-cycle response pipeline.
module synapse_weight_arbiter
    import synapse_mem_pkg::*;
#(
    parameter int NUM_SYNAPSES  = SYN_NUM_SYNAPSES,
    parameter int ADDR_W        = SYN_ADDR_W,
    parameter int WEIGHT_W      = SYN_WEIGHT_W,
    parameter int NUM_REQ       = 4,
    parameter int CFG_BURST_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        rd_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] rd_req_addr,
    output logic [NUM_REQ-1:0]        rd_req_ready,
    output logic [NUM_REQ-1:0]        rd_rsp_valid,
    output logic [WEIGHT_W-1:0]       rd_rsp_data,
    output logic                      rd_rsp_err,
    input  logic                      cfg_valid,
    input  logic                      cfg_we,
    input  logic [ADDR_W-1:0]         cfg_addr,
    input  logic [WEIGHT_W-1:0]       cfg_wdata,
    output logic                      cfg_ready,
    output logic                      cfg_rsp_valid,
    output logic [WEIGHT_W-1:0]       cfg_rsp_rdata,
    output logic                      cfg_rsp_err,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WEIGHT_W-1:0]       mem_wdata,
    input  logic [WEIGHT_W-1:0]       mem_rdata
);

    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STREAK_W = $clog2(CFG_BURST_MAX + 1);

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic [STREAK_W-1:0] cfg_streak;
    logic                cfg_block;
    logic                cfg_grant;
    logic                rd_grant_any;
    logic                acc_p0;
    logic [ADDR_W-1:0]   acc_addr_p0;
    logic                acc_err_p0;
    pipe_entry_t         ent_p0;
    pipe_entry_t         ent_p1;
    pipe_entry_t         ent_p2;
    logic                rsp_rd;
    logic                rsp_cfg;
    logic                rsp_err;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (rd_req_valid),
        .advance  (rd_grant_any),
        .grant    (arb_grant),
        .grant_idx(arb_idx)
    );

    // Stage 0: grant selection and range check, all combinational
    assign cfg_block    = (cfg_streak == STREAK_W'(CFG_BURST_MAX)) && (|rd_req_valid);
    assign cfg_grant    = rst && cfg_valid && !cfg_block;
    assign cfg_ready    = cfg_grant;
    assign rd_req_ready = arb_grant & {NUM_REQ{rst && !cfg_grant}};
    assign rd_grant_any = |rd_req_ready;
    assign acc_p0       = cfg_grant || rd_grant_any;

    assign acc_addr_p0 = cfg_grant ? cfg_addr : rd_req_addr[arb_idx*ADDR_W +: ADDR_W];
    assign acc_err_p0  = int'({1'b0, acc_addr_p0}) >= NUM_SYNAPSES;

    always_comb begin
        ent_p0        = '0;
        ent_p0.valid  = acc_p0;
        ent_p0.is_cfg = cfg_grant;
        ent_p0.is_wr  = cfg_grant && cfg_we;
        ent_p0.req_id = cfg_grant ? '0 : REQ_ID_W'(arb_idx);
        ent_p0.err    = acc_err_p0 ? RSP_ERR_RANGE : RSP_OK;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_streak <= '0;
        end else if (!cfg_grant) begin
            cfg_streak <= '0;
        end else if (cfg_streak != STREAK_W'(CFG_BURST_MAX)) begin
            cfg_streak <= cfg_streak + 1'b1;
        end
    end

    // Stage 1: RAM command, suppressed for out-of-range addresses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_p1    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ent_p1 <= ent_p0;
            mem_en <= acc_p0 && !acc_err_p0;
            mem_we <= cfg_grant && cfg_we && !acc_err_p0;
            if (acc_p0) begin
                mem_addr  <= acc_addr_p0;
                mem_wdata <= cfg_wdata;
            end
        end
    end

    // Stage 2: qualify the RAM output into the response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_p2 <= '0;
        end else begin
            ent_p2 <= ent_p1;
        end
    end

    assign rsp_rd  = ent_p2.valid && !ent_p2.is_cfg;
    assign rsp_cfg = ent_p2.valid && ent_p2.is_cfg;
    assign rsp_err = ent_p2.err == RSP_ERR_RANGE;

    always_comb begin
        rd_rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_rsp_valid[i] = rsp_rd && (ent_p2.req_id == REQ_ID_W'(i));
        end
    end

    assign rd_rsp_err    = rsp_rd && rsp_err;
    assign rd_rsp_data   = (rsp_rd && !rsp_err) ? mem_rdata : '0;
    assign cfg_rsp_valid = rsp_cfg;
    assign cfg_rsp_err   = rsp_cfg && rsp_err;
    assign cfg_rsp_rdata = (rsp_cfg && !ent_p2.is_wr && !rsp_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_synapse_weight_arbiter.sv
// Directed bench for synapse_weight_arbiter with a behavioural single-port RAM.
`timescale 1ns/1ps
module tb_synapse_weight_arbiter;

    localparam int NSYN = 72903;
    localparam int AW   = 17;
    localparam int WW   = 16;
    localparam int NR   = 4;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    rd_req_valid;
    logic [NR*AW-1:0] rd_req_addr;
    logic [NR-1:0]    rd_req_ready;
    logic [NR-1:0]    rd_rsp_valid;
    logic [WW-1:0]    rd_rsp_data;
    logic             rd_rsp_err;
    logic             cfg_valid;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [WW-1:0]    cfg_wdata;
    logic             cfg_ready;
    logic             cfg_rsp_valid;
    logic [WW-1:0]    cfg_rsp_rdata;
    logic             cfg_rsp_err;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WW-1:0]    mem_wdata;
    logic [WW-1:0]    mem_rdata;

    int errors = 0;
    int checks = 0;

    synapse_weight_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req_valid (rd_req_valid),
        .rd_req_addr  (rd_req_addr),
        .rd_req_ready (rd_req_ready),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .rd_rsp_err   (rd_rsp_err),
        .cfg_valid    (cfg_valid),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_ready    (cfg_ready),
        .cfg_rsp_valid(cfg_rsp_valid),
        .cfg_rsp_rdata(cfg_rsp_rdata),
        .cfg_rsp_err  (cfg_rsp_err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations read back a fixed pattern derived from the address
    function automatic logic [WW-1:0] init_val(input logic [AW-1:0] a);
        return a[WW-1:0] ^ 16'hC3A5;
    endfunction

    logic [WW-1:0] ram     [0:NSYN-1];
    bit            ram_set [0:NSYN-1];

    always @(posedge clk) begin
        if (mem_en && (int'({1'b0, mem_addr}) < NSYN)) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                ram_set[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_set[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        rd_req_valid = 4'hF;
        rd_req_addr  = '0;
        cfg_valid    = 1'b1;
        cfg_we       = 1'b0;
        cfg_addr     = '0;
        cfg_wdata    = '0;

        // Reset state with requests presented
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_rd_ready", rd_req_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rd_rsp_valid", rd_rsp_valid, 0);
        chk("rst_rd_rsp_data", rd_rsp_data, 0);
        chk("rst_cfg_rsp_valid", cfg_rsp_valid, 0);
        chk("rst_cfg_rsp_rdata", cfg_rsp_rdata, 0);
        @(negedge clk);
        rst          = 1'b1;
        rd_req_valid = '0;
        cfg_valid    = 1'b0;
        @(negedge clk);

        // Config write 0x1234 to addr 5, then requester 2 reads it back
        cfg_valid = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 17'd5;
        cfg_wdata = 16'h1234;
        #1;
        chk("wr_cfg_ready", cfg_ready, 1);
        chk("wr_rd_ready_idle", rd_req_ready, 0);
        @(negedge clk);
        cfg_valid              = 1'b0;
        cfg_we                 = 1'b0;
        rd_req_valid           = 4'b0100;
        rd_req_addr[2*AW +: AW] = 17'd5;
        #1;
        chk("wr_mem_en", mem_en, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 5);
        chk("wr_mem_wdata", mem_wdata, 32'h1234);
        chk("rd2_ready", rd_req_ready, 4'b0100);
        @(negedge clk);
        rd_req_valid = '0;
        #1;
        chk("wr_cfg_rsp_valid", cfg_rsp_valid, 1);
        chk("wr_cfg_rsp_err", cfg_rsp_err, 0);
        chk("wr_cfg_rsp_rdata", cfg_rsp_rdata, 0);
        chk("rd2_mem_en", mem_en, 1);
        chk("rd2_mem_we", mem_we, 0);
        chk("rd2_mem_addr", mem_addr, 5);
        @(negedge clk);
        #1;
        chk("rd2_rsp_valid", rd_rsp_valid, 4'b0100);
        chk("rd2_rsp_data", rd_rsp_data, 32'h1234);
        chk("rd2_rsp_err", rd_rsp_err, 0);
        chk("rd2_cfg_rsp_quiet", cfg_rsp_valid, 0);

        // Out of range: cfg read at 72903, requester 0 at 100000
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 17'd72903;
        #1;
        chk("oor_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        cfg_valid             = 1'b0;
        rd_req_valid          = 4'b0001;
        rd_req_addr[0 +: AW]  = 17'd100000;
        #1;
        chk("oor_cfg_mem_en", mem_en, 0);
        chk("oor_rd0_ready", rd_req_ready, 4'b0001);
        @(negedge clk);
        rd_req_valid = '0;
        #1;
        chk("oor_rd_mem_en", mem_en, 0);
        chk("oor_cfg_rsp_valid", cfg_rsp_valid, 1);
        chk("oor_cfg_rsp_err", cfg_rsp_err, 1);
        chk("oor_cfg_rsp_rdata", cfg_rsp_rdata, 0);
        @(negedge clk);
        #1;
        chk("oor_idle_mem_en", mem_en, 0);
        chk("oor_rd_rsp_valid", rd_rsp_valid, 4'b0001);
        chk("oor_rd_rsp_err", rd_rsp_err, 1);
        chk("oor_rd_rsp_data", rd_rsp_data, 0);

        // Starvation guard: 20 config reads against a held requester 1
        @(negedge clk);
        cfg_valid             = 1'b1;
        cfg_we                = 1'b0;
        cfg_addr              = 17'd7;
        rd_req_valid          = 4'b0010;
        rd_req_addr[1*AW +: AW] = 17'd9;
        for (int c = 0; c < 22; c++) begin
            #1;
            chk("sg_cfg_ready", cfg_ready, (c % 9 == 8) ? 0 : 1);
            chk("sg_rd_ready", rd_req_ready, (c % 9 == 8) ? 4'b0010 : 4'b0000);
            if (c == 10) begin
                chk("sg_rd_rsp_valid", rd_rsp_valid, 4'b0010);
                chk("sg_rd_rsp_data", rd_rsp_data, 32'(init_val(17'd9)));
                chk("sg_cfg_rsp_quiet", cfg_rsp_valid, 0);
            end
            if (c == 11) begin
                chk("sg_cfg_rsp_data", cfg_rsp_rdata, 32'(init_val(17'd7)));
            end
            @(negedge clk);
        end
        cfg_valid    = 1'b0;
        rd_req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Reset one cycle after two reads are accepted
        rd_req_valid          = 4'b0001;
        rd_req_addr[0 +: AW]  = 17'd20;
        @(negedge clk);
        rd_req_valid            = 4'b0010;
        rd_req_addr[1*AW +: AW] = 17'd21;
        @(negedge clk);
        rst          = 1'b0;
        rd_req_valid = 4'hF;
        #1;
        chk("mid_rst_rsp_valid", rd_rsp_valid, 0);
        chk("mid_rst_rsp_data", rd_rsp_data, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_rd_ready", rd_req_ready, 0);
        @(negedge clk);
        #1;
        chk("mid_rst_hold_rsp", rd_rsp_valid, 0);
        @(negedge clk);
        rst          = 1'b1;
        rd_req_valid = '0;
        #1;
        chk("post_rst_rsp", rd_rsp_valid, 0);
        chk("post_rst_mem_en", mem_en, 0);
        @(negedge clk);
        #1;
        chk("post_rst_rsp2", rd_rsp_valid, 0);

        // Round-robin with all requesters held, starting fresh from reset
        for (int i = 0; i < NR; i++) begin
            rd_req_addr[i*AW +: AW] = AW'(16 + i);
        end
        @(negedge clk);
        rd_req_valid = 4'hF;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) begin
                rd_req_valid = '0;
            end
            #1;
            if (k < 8) begin
                chk("rr_grant", rd_req_ready, 32'(1) << (k % 4));
            end
            if (k >= 2) begin
                chk("rr_rsp_valid", rd_rsp_valid, 32'(1) << ((k - 2) % 4));
                chk("rr_rsp_data", rd_rsp_data, 32'(init_val(AW'(16 + (k - 2) % 4))));
            end
            @(negedge clk);
        end
        #1;
        chk("rr_drained", rd_rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
